// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter that lets NUM_REQ read masters share one AXI4 AR/R channel pair.
// Only one transaction is in flight at a time; ownership is held from AR grant to the last R beat.
module axi_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
  input  logic [NUM_REQ*8-1:0]          req_arlen,
  input  logic [NUM_REQ-1:0]            req_arvalid,
  output logic [NUM_REQ-1:0]            req_arready,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]            req_rvalid,
  input  logic [NUM_REQ-1:0]            req_rready,
  output logic [ADDR_WIDTH-1:0]         m_araddr,
  output logic [7:0]                    m_arlen,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [8:0]      beats_q, beats_d;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [7:0]            len_arr  [NUM_REQ];
  logic [GW-1:0]         pick;
  logic [GW-1:0]         cand;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      len_arr[i]  = req_arlen[i*8 +: 8];
    end
  end

  // Walk candidates from farthest to nearest after last_q so the nearest requester wins.
  always_comb begin
    pick = last_q;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = GW'((int'(last_q) + k) % NUM_REQ);
      if (req_arvalid[cand]) pick = cand;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beats_d = beats_q;
    unique case (state_q)
      IDLE: begin
        if (|req_arvalid) begin
          grant_d = pick;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (!req_arvalid[grant_q]) begin
          state_d = IDLE;
        end else if (m_arready) begin
          beats_d = 9'(len_arr[grant_q]) + 9'd1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (m_rvalid && req_rready[grant_q]) begin
          beats_d = beats_q - 9'd1;
          if (beats_q == 9'd1) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_araddr    = '0;
    m_arlen     = '0;
    m_arvalid   = 1'b0;
    req_arready = '0;
    m_rready    = 1'b0;
    req_rvalid  = '0;
    if (state_q == ADDR) begin
      m_araddr             = addr_arr[grant_q];
      m_arlen              = len_arr[grant_q];
      m_arvalid            = req_arvalid[grant_q];
      req_arready[grant_q] = m_arready;
    end
    if (state_q == DATA) begin
      m_rready            = req_rready[grant_q];
      req_rvalid[grant_q] = m_rvalid;
    end
  end

  assign req_rdata = m_rdata;
  assign grant_id  = grant_q;
  assign busy      = (state_q != IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beats_q <= beats_d;
    end
  end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of read requesters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, AXI data width.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_araddr  in  NUM_REQ*ADDR_WIDTH  per-requester read address, requester i in slice i.
REQ-007 SHALL have port req_arlen  in  NUM_REQ*8  per-requester burst length minus one.
REQ-008 SHALL have port req_arvalid  in  NUM_REQ  per-requester address valid.
REQ-009 SHALL have port req_arready  out  NUM_REQ  per-requester address accept.
REQ-010 SHALL have port req_rdata  out  DATA_WIDTH  read data, broadcast to all requesters.
REQ-011 SHALL have port req_rvalid  out  NUM_REQ  per-requester data valid.
REQ-012 SHALL have port req_rready  in  NUM_REQ  per-requester data ready.
REQ-013 SHALL have ports m_araddr out ADDR_WIDTH, m_arlen out 8, m_arvalid out 1, m_arready in 1: shared AXI4 AR channel.
REQ-014 SHALL have ports m_rdata in DATA_WIDTH, m_rvalid in 1, m_rready out 1: shared AXI4 R channel.
REQ-015 SHALL have ports grant_id out $clog2(NUM_REQ), busy out 1: current owner index and ownership-active flag.

Function
REQ-016 SHALL implement FSM states IDLE, ADDR, DATA; busy SHALL be high exactly in ADDR and DATA.
REQ-017 In IDLE with any req_arvalid high, SHALL select the first asserting requester searching upward from (last_grant+1) mod NUM_REQ, register it into grant_id, and enter ADDR the next cycle.
REQ-018 In IDLE with no req_arvalid high, SHALL stay in IDLE; grant_id SHALL hold its value.
REQ-019 In ADDR, m_araddr, m_arlen, and m_arvalid SHALL combinationally follow the granted requester's slices; req_arready[grant_id] SHALL equal m_arready; all other req_arready bits SHALL be 0.
REQ-020 On an ADDR cycle with m_arvalid and m_arready both high, SHALL load beat counter with m_arlen+1 (9-bit, range 1..256) and enter DATA.
REQ-021 In ADDR, if req_arvalid[grant_id] drops before the handshake, SHALL return to IDLE with no transaction issued and last_grant unchanged.
REQ-022 In DATA, m_rready SHALL equal req_rready[grant_id]; req_rvalid[grant_id] SHALL equal m_rvalid; all other req_rvalid bits SHALL be 0; req_rdata SHALL equal m_rdata in all states.
REQ-023 Each DATA cycle with m_rvalid and m_rready both high SHALL decrement the beat counter by 1.
REQ-024 On the beat that decrements the counter from 1 to 0, SHALL enter IDLE and set last_grant to grant_id.
REQ-025 Outside ADDR: m_arvalid=0, m_araddr=0, m_arlen=0, and all req_arready bits=0. Outside DATA: m_rready=0 and all req_rvalid bits=0.
REQ-026 SHALL hold exactly one outstanding transaction; no AR handshake SHALL occur while in DATA.
REQ-027 Minimum spacing SHALL be one IDLE arbitration cycle between the last R beat and the next m_arvalid.
REQ-028 m_rvalid asserting in IDLE or ADDR SHALL be ignored: no counter change, m_rready stays 0.

Reset
REQ-029 While rst is high at a clock edge, SHALL enter IDLE, clear the beat counter, set grant_id=0 and last_grant=NUM_REQ-1 so requester 0 has first priority.
REQ-030 Reset asserted mid-ADDR or mid-DATA SHALL abandon the transaction; all outputs SHALL take their REQ-025 values the cycle after the reset edge.

Verification
REQ-031 Single requester: req_arvalid=4'b0100, addr 0x100, arlen 0, m_arready=1 -> grant_id=2, one AR 0x100, one beat routed only to req_rvalid[2], busy low after the beat.
REQ-032 Round-robin: all four req_arvalid held high with single-beat transactions -> grant order 0,1,2,3,0; never the same requester twice while others wait.
REQ-033 Burst: requester 1 arlen=7, m_rvalid toggled every other cycle -> exactly 8 beats forwarded; IDLE entered on the 8th handshake; requester 3 not granted before then.
REQ-034 Backpressure: m_arready low for 5 cycles in ADDR -> m_arvalid and m_araddr held stable; one handshake when m_arready rises.
REQ-035 Withdrawn request: req_arvalid[0] dropped in ADDR before m_arready -> IDLE next cycle, no AR issued, and requester 0 still first in priority on re-request.
REQ-036 Reset mid-burst: rst pulsed after 3 of 8 beats -> IDLE, busy=0, m_rready=0, grant_id=0 the following cycle.
